// File: rtl/afc_pkg.sv
// Shared decision encodings and comparator state type for the AFC loop.
// The decision codes are also used by the downstream AFC search FSM.
package afc_pkg;

  localparam logic [2:0] COMP_NONE   = 3'b000;
  localparam logic [2:0] COMP_FREEZE = 3'b001;
  localparam logic [2:0] COMP_SLOW   = 3'b010;
  localparam logic [2:0] COMP_FAST   = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COUNT,
    DECIDE
  } afc_cmp_state_t;

endpackage

// File: rtl/afc_edge_sync.sv
// Two-flop synchronizer for an asynchronous input plus a rising-edge detector.
// The rise pulse lasts one clk cycle and appears two edges after d goes high.
module afc_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], d};
    prev_d = sync_q[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[1] & ~prev_q;

endmodule

// File: rtl/afc_freq_comparator.sv
// Counts divided-VCO edges over a fixed window and issues fast/slow/freeze decisions.
// Define AFC_CMP_TOL_EN to widen the freeze decision into a +/-TOL band.
module afc_freq_comparator
  import afc_pkg::*;
#(
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned WINDOW     = 256,
  parameter int unsigned SETTLE_CYC = 32,
  parameter int unsigned TOL        = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vco_div,
  input  logic [CNT_W-1:0] target,
  input  logic             start,
  input  logic             fsm_done,
  output logic [2:0]       comp_out,
  output logic             comp_valid,
  output logic             busy,
  output logic [CNT_W-1:0] count_out
);

  localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned WinW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [SetW-1:0] SettleLoad = SetW'(SETTLE_CYC - 1);
  localparam logic [WinW-1:0] WinLoad    = WinW'(WINDOW - 1);

  afc_cmp_state_t   state_q, state_d;
  logic [SetW-1:0]  settle_q, settle_d;
  logic [WinW-1:0]  win_q, win_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic [CNT_W-1:0] count_out_q, count_out_d;
  logic [2:0]       comp_out_q, comp_out_d;
  logic             comp_valid_q, comp_valid_d;
  logic             busy_q, busy_d;
  logic             vco_rise;
  logic [2:0]       decision;

  afc_edge_sync u_vco_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (vco_div),
    .rise (vco_rise)
  );

  // Compare one bit wider than the counter so target+TOL cannot wrap.
  always_comb begin
    logic [CNT_W:0] cnt_ext;
    logic [CNT_W:0] tgt_ext;
    cnt_ext  = {1'b0, edge_q};
    tgt_ext  = {1'b0, target};
    decision = COMP_FREEZE;
`ifdef AFC_CMP_TOL_EN
    begin
      logic [CNT_W:0] tol_ext;
      logic [CNT_W:0] hi;
      logic [CNT_W:0] lo;
      tol_ext = (CNT_W+1)'(TOL);
      hi      = tgt_ext + tol_ext;
      lo      = (tgt_ext > tol_ext) ? (tgt_ext - tol_ext) : '0;
      if (cnt_ext > hi) begin
        decision = COMP_FAST;
      end else if (cnt_ext < lo) begin
        decision = COMP_SLOW;
      end
    end
`else
    if (cnt_ext > tgt_ext) begin
      decision = COMP_FAST;
    end else if (cnt_ext < tgt_ext) begin
      decision = COMP_SLOW;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    win_d        = win_q;
    edge_d       = edge_q;
    count_out_d  = count_out_q;
    comp_out_d   = COMP_NONE;
    comp_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !fsm_done) begin
          state_d  = SETTLE;
          settle_d = SettleLoad;
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          state_d = COUNT;
          edge_d  = '0;
          win_d   = WinLoad;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      COUNT: begin
        if (vco_rise && (edge_q != '1)) begin
          edge_d = edge_q + 1'b1;
        end
        if (win_q == '0) begin
          state_d = DECIDE;
        end else begin
          win_d = win_q - 1'b1;
        end
      end
      DECIDE: begin
        comp_out_d   = decision;
        comp_valid_d = 1'b1;
        count_out_d  = edge_q;
        if (decision == COMP_FREEZE) begin
          state_d = IDLE;
        end else begin
          state_d  = SETTLE;
          settle_d = SettleLoad;
        end
      end
      default: state_d = IDLE;
    endcase

    // Downstream FSM finished: abort, suppressing any decision in flight.
    if (fsm_done) begin
      state_d      = IDLE;
      comp_out_d   = COMP_NONE;
      comp_valid_d = 1'b0;
      count_out_d  = count_out_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      settle_q     <= '0;
      win_q        <= '0;
      edge_q       <= '0;
      count_out_q  <= '0;
      comp_out_q   <= COMP_NONE;
      comp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      win_q        <= win_d;
      edge_q       <= edge_d;
      count_out_q  <= count_out_d;
      comp_out_q   <= comp_out_d;
      comp_valid_q <= comp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign comp_out   = comp_out_q;
  assign comp_valid = comp_valid_q;
  assign busy       = busy_q;
  assign count_out  = count_out_q;

endmodule

// File: tb/tb_afc_freq_comparator.sv
// Scoreboard bench for afc_freq_comparator: directed vco_div periods, aborts and resets.
// Expectations follow AFC_CMP_TOL_EN when the bench is built with it.
module tb_afc_freq_comparator;

  localparam int LAT = 32 + 256 + 1;

  logic       clk;
  logic       rst_n;
  logic       vco_div;
  logic [9:0] target;
  logic       start;
  logic       fsm_done;
  logic [2:0] comp_out;
  logic       comp_valid;
  logic       busy;
  logic [9:0] count_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int per   = 4;

  typedef struct {
    logic [2:0] code;
    int         lo;
    int         hi;
    int         at;
  } exp_t;

  exp_t sb[$];

  afc_freq_comparator #(
    .CNT_W     (10),
    .WINDOW    (256),
    .SETTLE_CYC(32),
    .TOL       (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vco_div   (vco_div),
    .target    (target),
    .start     (start),
    .fsm_done  (fsm_done),
    .comp_out  (comp_out),
    .comp_valid(comp_valid),
    .busy      (busy),
    .count_out (count_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // vco_div edges land 2 time units off the clk grid to avoid races.
  initial begin
    vco_div = 1'b0;
    #2;
    forever begin
      if (per == 0) begin
        vco_div = 1'b0;
        #10;
      end else begin
        vco_div = 1'b1;
        #(per * 5);
        vco_div = 1'b0;
        #(per * 5);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every decision pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("valid_vs_code", int'(comp_out != 3'b000), int'(comp_valid));
        if (comp_valid) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_decision: got code %b at cycle %0d expected none",
                     comp_out, cyc);
          end else begin
            e = sb.pop_front();
            chk("decision_code", int'(comp_out), int'(e.code));
            chk("decision_cycle", cyc, e.at);
            total++;
            if (int'(count_out) < e.lo || int'(count_out) > e.hi) begin
              bad++;
              $display("FAIL count_out: got %0d expected %0d..%0d", count_out, e.lo, e.hi);
            end
          end
        end
      end
    end
  end

  task automatic start_pulse(output int k);
    @(negedge clk);
    chk("busy_before_start", int'(busy), 0);
    start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic expect_n(input int k, input int n, input logic [2:0] code, input int lo,
                          input int hi);
    exp_t e;
    for (int i = 1; i <= n; i++) begin
      e.code = code;
      e.lo   = lo;
      e.hi   = hi;
      e.at   = k + LAT * i;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic abort_cal();
    @(negedge clk);
    fsm_done = 1'b1;
    @(negedge clk);
    fsm_done = 1'b0;
    chk("busy_after_abort", int'(busy), 0);
    chk("valid_after_abort", int'(comp_valid), 0);
  endtask

  initial begin
    int k;
    rst_n    = 1'b0;
    start    = 1'b0;
    fsm_done = 1'b0;
    target   = 10'd64;
    #23;
    chk("rst_comp_out", int'(comp_out), 0);
    chk("rst_comp_valid", int'(comp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count_out", int'(count_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Period 4, exact 64 edges: freeze, then idle.
    per = 4;
    repeat (10) @(negedge clk);
    start_pulse(k);
    expect_n(k, 1, 3'b001, 64, 64);
    wait_drain(LAT + 20);
    chk("busy_after_freeze", int'(busy), 0);
    @(negedge clk);
    chk("valid_one_cycle", int'(comp_valid), 0);

    // Period 5: repeated slow decisions every LAT cycles.
    per = 5;
    repeat (10) @(negedge clk);
    start_pulse(k);
    expect_n(k, 2, 3'b010, 51, 52);
    wait_drain(2 * LAT + 20);
    abort_cal();

    // Period 3: fast.
    per = 3;
    repeat (10) @(negedge clk);
    start_pulse(k);
    expect_n(k, 1, 3'b100, 85, 86);
    wait_drain(LAT + 20);
    abort_cal();

    // Target 66 with count 64: inside the band only with tolerance enabled.
    per    = 4;
    target = 10'd66;
    repeat (10) @(negedge clk);
    start_pulse(k);
`ifdef AFC_CMP_TOL_EN
    expect_n(k, 1, 3'b001, 64, 64);
`else
    expect_n(k, 1, 3'b010, 64, 64);
`endif
    wait_drain(LAT + 20);
    abort_cal();

    // fsm_done during COUNT: abort, no decision afterwards.
    target = 10'd64;
    start_pulse(k);
    repeat (100) @(negedge clk);
    chk("busy_in_count", int'(busy), 1);
    abort_cal();
    repeat (LAT + 10) @(negedge clk);
    chk("idle_after_abort", int'(busy), 0);

    // Reset mid-window clears everything; restart gives full latency.
    start_pulse(k);
    repeat (150) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_comp_out", int'(comp_out), 0);
    chk("midrst_comp_valid", int'(comp_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_count_out", int'(count_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    start_pulse(k);
    expect_n(k, 1, 3'b001, 64, 64);
    wait_drain(LAT + 20);

    // vco_div stuck low: count 0.
    per = 0;
    repeat (10) @(negedge clk);
    start_pulse(k);
    expect_n(k, 1, 3'b010, 0, 0);
    wait_drain(LAT + 20);
    abort_cal();

    // Target 1 with count 0: clamped band reaches 0 only with tolerance enabled.
    target = 10'd1;
    start_pulse(k);
`ifdef AFC_CMP_TOL_EN
    expect_n(k, 1, 3'b001, 0, 0);
`else
    expect_n(k, 1, 3'b010, 0, 0);
`endif
    wait_drain(LAT + 20);
    abort_cal();

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/afc_freq_comparator.md
# afc_freq_comparator

Measures the divided VCO clock against the reference clock over a fixed counting window and issues one fast/slow/freeze decision per measurement to the 6-bit AFC search FSM. Sits directly upstream of that FSM: its `comp_out` drives the FSM's `comp_in`, and the FSM's finished flag (`state_out[5]`) returns as `fsm_done`. Each decision is followed by a settle interval, so the VCO can respond to the new capacitor code before the next measurement.

## Interface
- `CNT_W`, default 10: width of the edge counter, `target` and `count_out`.
- `WINDOW`, default 256: length of the counting window, in `clk` cycles.
- `SETTLE_CYC`, default 32: settle interval, in `clk` cycles, before each window.
- `TOL`, default 2: freeze tolerance band, in counts. Used only when the tolerance feature is compiled in.
- `clk`  in  1: reference clock. Single clock domain.
- `rst_n`  in  1: asynchronous, active-low reset.
- `vco_div`  in  1: divided VCO clock. Asynchronous to `clk`; its frequency must be below `clk`/2.
- `target`  in  CNT_W: expected number of `vco_div` rising edges per window. Static while `busy`.
- `start`  in  1: level-sampled request to begin calibration. Ignored while `busy`.
- `fsm_done`  in  1: finished flag from the downstream FSM. Aborts calibration.
- `comp_out`  out  3: one-hot decision. 3'b100 fast, 3'b010 slow, 3'b001 freeze, 3'b000 no decision.
- `comp_valid`  out  1: high for exactly the one cycle in which `comp_out` is non-zero.
- `busy`  out  1: high in every state except IDLE.
- `count_out`  out  CNT_W: edge count from the most recent window. Held until the next DECIDE.

## Operation
- States: IDLE, SETTLE, COUNT, DECIDE.
- IDLE, `start`=1 and `fsm_done`=0: go to SETTLE and load the settle counter with SETTLE_CYC-1.
- SETTLE: decrement the settle counter each cycle. At 0, go to COUNT, clear the edge counter, and load the window counter with WINDOW-1.
- COUNT: add 1 to the edge counter for each rising edge of the synchronized `vco_div`. The edge counter saturates at 2^CNT_W-1 and never wraps. When the window counter reaches 0, go to DECIDE.
- DECIDE (one cycle): register the decision into `comp_out`, set `comp_valid`=1 and update `count_out`.
  - Freeze: go to IDLE.
  - Fast or slow: go to SETTLE.
- Decision rule, evaluated in CNT_W+1 bits:
  - count > target+TOL: fast.
  - count < target-TOL: slow. target-TOL clamps at 0.
  - Otherwise: freeze.
- `fsm_done`=1 in any state forces IDLE on the next edge. That edge also drives `comp_out`=3'b000 and `comp_valid`=0, and this overrides a DECIDE in the same cycle.
- `start` and `fsm_done` high in the same cycle while in IDLE: stay in IDLE.
- The synchronizer and edge detector run continuously, in all states.
- Reset values: `comp_out`=3'b000, `comp_valid`=0, `busy`=0, `count_out`=0, state IDLE. All counters and synchronizer flops are 0.
- Reset asserted mid-measurement: every register clears asynchronously. No decision is emitted.

## Timing
- All outputs are registered.
- `start` sampled at edge k: `busy`=1 from edge k+1.
- First decision: `comp_valid`=1 in the cycle following edge k+SETTLE_CYC+WINDOW+1.
- Each later decision follows the previous one after SETTLE_CYC+WINDOW+1 cycles.
- `vco_div` to counter latency: 3 cycles (2-flop synchronizer plus edge-detect flop).
  - Edges arriving in the last 3 cycles of SETTLE are counted in the window.
  - Edges arriving in the last 3 cycles of COUNT are lost.
  - This bias is deterministic and is absorbed by `target`.
- `comp_out` is 3'b000 in every cycle except DECIDE. The downstream FSM therefore advances exactly once per decision.

## Configuration
- `AFC_CMP_TOL_EN` defined: the TOL band applies as described above.
- Not defined: TOL is ignored.
  - Freeze only when count == target.
  - Fast when count > target; slow when count < target.
  - The clamp logic is not synthesized.

## Structure
- Package `afc_pkg` holds:
  - Localparams COMP_NONE=3'b000, COMP_FREEZE=3'b001, COMP_SLOW=3'b010, COMP_FAST=3'b100. These are shared with the AFC FSM.
  - The `afc_cmp_state_t` enum: IDLE, SETTLE, COUNT, DECIDE.
- Sub-module `afc_edge_sync`: 2-flop synchronizer plus rising-edge detector. Takes `clk`, `rst_n` and async input `d`; outputs a one-cycle `rise` pulse.

## Test plan
Default parameters, `target`=64.
- `vco_div` period 4 `clk`: count 64±1. One `comp_valid` pulse with 3'b001 at cycle SETTLE_CYC+WINDOW+1 after `start`, then `busy`=0.
- `vco_div` period 5 `clk`: count about 51. 3'b010 repeated every 289 cycles while `start` is held low.
- `vco_div` period 3 `clk`: count about 85. 3'b100.
- `target`=66 with period 4 (count 64):
  - With `AFC_CMP_TOL_EN`: 3'b001.
  - Without it: 3'b010.
- `fsm_done` pulsed during COUNT: IDLE next cycle, `busy`=0, no `comp_valid`.
- `rst_n` low mid-window: all outputs 0 immediately. A fresh `start` after release gives full first-decision latency.
- `vco_div` stuck low: count 0, 3'b010. With `target`=1 and `TOL`=2, the clamped band gives 3'b001.
